inner_product_acc: RTL and testbench

Parametrised successor to inner_product: a signed fixed-point dot-product engine for the matrix multiplier datapath.
- Consumes one packed row vector and one packed column vector of N elements through stb/ack handshakes.
- Performs one multiply-accumulate per cycle and presents the result on a stb/ack output.
- Adds an accumulate mode, so partial dot products of tiled matrices chain across transactions.
- Adds saturation with a sticky overflow flag.

---
 rtl/inner_product_acc.sv | 135 +++++++++++++
 tb/tb_inner_product_acc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/inner_product_acc.sv
// Signed fixed-point dot-product engine: one saturating multiply-accumulate per cycle,
// optional chaining from the previous result, stb/ack handshakes on input and output.
module inner_product_mac_step #(
    parameter int ELEMENT_WIDTH = 16,
    parameter int ACC_WIDTH     = 34
) (
    input  logic signed [ELEMENT_WIDTH-1:0] a,
    input  logic signed [ELEMENT_WIDTH-1:0] b,
    input  logic signed [ACC_WIDTH-1:0]     acc,
    output logic signed [ACC_WIDTH-1:0]     acc_next,
    output logic                            ovf
);
    localparam int PW = 2*ELEMENT_WIDTH;
    localparam int SW = ACC_WIDTH + 1;

    logic signed [PW-1:0] prod;
    logic        [SW-1:0] sum;

    assign prod = a * b;
    // One guard bit is enough: |prod| never exceeds the accumulator range.
    assign sum  = {acc[ACC_WIDTH-1], acc} + {{(SW-PW){prod[PW-1]}}, prod};
    assign ovf  = sum[SW-1] ^ sum[SW-2];

    always_comb begin
        acc_next = sum[ACC_WIDTH-1:0];
        if (ovf)
            acc_next = sum[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
endmodule

module inner_product_acc #(
    parameter int ELEMENT_WIDTH      = 16,
    parameter int NUMBER_OF_ELEMENTS = 4,
    parameter int ACC_WIDTH          = 34
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [ELEMENT_WIDTH*NUMBER_OF_ELEMENTS-1:0] row,
    input  logic [ELEMENT_WIDTH*NUMBER_OF_ELEMENTS-1:0] column,
    input  logic                                        acc_i,
    input  logic                                        row_i_stb,
    input  logic                                        column_i_stb,
    output logic                                        row_i_ack,
    output logic                                        column_i_ack,
    output logic [ACC_WIDTH-1:0]                        out,
    output logic                                        out_ovf,
    output logic                                        out_o_stb,
    input  logic                                        out_o_ack
);
    localparam int VW = ELEMENT_WIDTH*NUMBER_OF_ELEMENTS;
    localparam int KW = (NUMBER_OF_ELEMENTS > 1) ? $clog2(NUMBER_OF_ELEMENTS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUMBER_OF_ELEMENTS - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, MAC, OUTPUT} state_t;

    state_t                       state;
    logic [VW-1:0]                row_r, column_r;
    logic                         acc_mode;
    logic [KW-1:0]                k;
    logic signed [ACC_WIDTH-1:0]  acc, prev, acc_next;
    logic                         ovf, step_ovf;

    // Operand registers shift down one element per MAC cycle, so element k sits at the bottom.
    inner_product_mac_step #(
        .ELEMENT_WIDTH(ELEMENT_WIDTH),
        .ACC_WIDTH    (ACC_WIDTH)
    ) u_step (
        .a       (row_r[ELEMENT_WIDTH-1:0]),
        .b       (column_r[ELEMENT_WIDTH-1:0]),
        .acc     (acc),
        .acc_next(acc_next),
        .ovf     (step_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            row_r        <= '0;
            column_r     <= '0;
            acc_mode     <= 1'b0;
            k            <= '0;
            acc          <= '0;
            prev         <= '0;
            ovf          <= 1'b0;
            row_i_ack    <= 1'b0;
            column_i_ack <= 1'b0;
            out          <= '0;
            out_ovf      <= 1'b0;
            out_o_stb    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (row_i_stb && column_i_stb) begin
                        row_r        <= row;
                        column_r     <= column;
                        acc_mode     <= acc_i;
                        row_i_ack    <= 1'b1;
                        column_i_ack <= 1'b1;
                        state        <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    row_i_ack    <= 1'b0;
                    column_i_ack <= 1'b0;
                    acc          <= acc_mode ? prev : '0;
                    k            <= '0;
                    ovf          <= 1'b0;
                    state        <= MAC;
                end
                MAC: begin
                    acc      <= acc_next;
                    ovf      <= ovf | step_ovf;
                    row_r    <= row_r >> ELEMENT_WIDTH;
                    column_r <= column_r >> ELEMENT_WIDTH;
                    k        <= k + 1'b1;
                    if (k == K_LAST) begin
                        out       <= acc_next;
                        out_ovf   <= ovf | step_ovf;
                        out_o_stb <= 1'b1;
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_o_ack) begin
                        prev      <= acc;
                        out_o_stb <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inner_product_acc.sv
// Scoreboard bench: drives the default (34-bit) and a 32-bit accumulator instance in lockstep
// against a plain-arithmetic reference model.
module tb_inner_product_acc;
    localparam int EW = 16;
    localparam int N  = 4;
    localparam int VW = EW*N;

    logic          clk = 1'b0, rst = 1'b1;
    logic [VW-1:0] row = '0, column = '0;
    logic          acc_i = 1'b0, row_i_stb = 1'b0, column_i_stb = 1'b0, out_o_ack = 1'b1;

    logic          ra34, ca34, os34, ov34;
    logic [33:0]   out34;
    logic          ra32, ca32, os32, ov32;
    logic [31:0]   out32;

    always #5 clk = ~clk;

    inner_product_acc dut34 (
        .clk(clk), .rst(rst), .row(row), .column(column), .acc_i(acc_i),
        .row_i_stb(row_i_stb), .column_i_stb(column_i_stb),
        .row_i_ack(ra34), .column_i_ack(ca34), .out(out34), .out_ovf(ov34),
        .out_o_stb(os34), .out_o_ack(out_o_ack));

    inner_product_acc #(.ACC_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .row(row), .column(column), .acc_i(acc_i),
        .row_i_stb(row_i_stb), .column_i_stb(column_i_stb),
        .row_i_ack(ra32), .column_i_ack(ca32), .out(out32), .out_ovf(ov32),
        .out_o_stb(os32), .out_o_ack(out_o_ack));

    typedef struct {
        longint o34; bit v34;
        longint o32; bit v32;
    } exp_t;

    exp_t   sb[$];
    longint prev34 = 0, prev32 = 0;
    int     checks = 0, passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [VW-1:0] pack(input int e0, input int e1, input int e2, input int e3);
        logic [VW-1:0] v;
        v = {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
        return v;
    endfunction

    // Dot product with clamping after every element, using plain 64-bit arithmetic.
    function automatic void model(input logic [VW-1:0] r, input logic [VW-1:0] c, input bit a,
                                  input int w, inout longint prev, output longint res, output bit ovf);
        longint mx, mn, acc;
        logic signed [EW-1:0] re, ce;
        mx  = (longint'(1) <<< (w-1)) - 1;
        mn  = -mx - 1;
        acc = a ? prev : 0;
        ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            re  = r[i*EW +: EW];
            ce  = c[i*EW +: EW];
            acc = acc + longint'(re) * longint'(ce);
            if (acc > mx) begin acc = mx; ovf = 1'b1; end
            else if (acc < mn) begin acc = mn; ovf = 1'b1; end
        end
        res  = acc;
        prev = acc;
    endfunction

    // Presents operands and waits for the acceptance ack; returns number of edges waited.
    task automatic issue(input logic [VW-1:0] r, input logic [VW-1:0] c, input bit a, output int waited);
        exp_t e;
        bit   got = 1'b0;
        row = r; column = c; acc_i = a;
        row_i_stb = 1'b1; column_i_stb = 1'b1;
        waited = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            waited++;
            if (ra34 || ca34) got = 1'b1;
        end
        if (!got) begin
            chk("ack_timeout", 0, 1);
        end else begin
            model(r, c, a, 34, prev34, e.o34, e.v34);
            model(r, c, a, 32, prev32, e.o32, e.v32);
            sb.push_back(e);
            chk("acks_coincident", {ra34, ca34, ra32, ca32}, 4'hF);
        end
        row_i_stb = 1'b0; column_i_stb = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", {ra34, ca34, ra32, ca32}, 0);
    endtask

    // Called one edge after acceptance; returns cycles from acceptance edge to out_o_stb.
    task automatic wait_out(output int lat);
        lat = 1;
        for (int i = 0; i < 40 && !os34; i++) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!os34) chk("out_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && os34 && out_o_ack) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out: got out=%0d expected none", $signed(out34));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out34", longint'($signed(out34)), e.o34);
                chk("ovf34", ov34, e.v34);
                chk("stb32", os32, 1);
                chk("out32", longint'($signed(out32)), e.o32);
                chk("ovf32", ov32, e.v32);
            end
        end
    end

    initial begin
        int w, lat;
        logic [VW-1:0] basic_r, basic_c, r, c;
        basic_r = pack(3, -2, 5, 7);
        basic_c = pack(4, 6, -1, 2);

        #2;
        chk("reset_state", {ra34, ca34, os34, ov34, ra32, ca32, os32, ov32}, 0);
        chk("reset_out", longint'(out34) | longint'(out32), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // basic + latency
        issue(basic_r, basic_c, 1'b0, w);
        wait_out(lat);
        chk("latency", lat, N + 1);
        chk("basic_out", longint'($signed(out34)), 9);
        @(posedge clk); #1;
        chk("release_one_cycle", os34, 0);

        // accumulate chain
        issue(pack(1, 1, 1, 1), pack(1, 2, 3, 4), 1'b1, w);
        wait_out(lat);
        chk("acc_out", longint'($signed(out34)), 19);
        @(posedge clk); #1;
        issue(pack(1, 1, 1, 1), pack(1, 2, 3, 4), 1'b0, w);
        wait_out(lat);
        chk("noacc_out", longint'($signed(out34)), 10);
        @(posedge clk); #1;

        // saturation on the 32-bit instance, then sticky flag clears on next transaction
        r = {N{16'h8000}};
        issue(r, r, 1'b0, w);
        wait_out(lat);
        chk("sat_out32", longint'(out32), 64'h7FFF_FFFF);
        chk("sat_ovf32", ov32, 1);
        @(posedge clk); #1;
        issue(pack(2, 3, 4, 5), pack(1, 1, 1, 1), 1'b0, w);
        wait_out(lat);
        chk("ovf_cleared", ov32, 0);
        @(posedge clk); #1;

        // back-pressure with new operands already strobing
        out_o_ack = 1'b0;
        issue(basic_r, basic_c, 1'b1, w);
        wait_out(lat);
        row = pack(-7, 8, 1, 0); column = pack(5, 5, -3, 9); acc_i = 1'b0;
        row_i_stb = 1'b1; column_i_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_stb", os34, 1);
            chk("bp_out", longint'($signed(out34)), sb[0].o34);
            chk("bp_no_ack", ra34 | ca34, 0);
        end
        out_o_ack = 1'b1;
        issue(pack(-7, 8, 1, 0), pack(5, 5, -3, 9), 1'b0, w);
        chk("bp_accept_delay", w, 2);
        wait_out(lat);
        @(posedge clk); #1;

        // single strobe does nothing
        row_i_stb = 1'b1; column_i_stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("single_stb_no_ack", ra34 | ca34, 0);
        end
        issue(basic_r, basic_c, 1'b0, w);
        chk("both_stb_ack_delay", w, 1);
        wait_out(lat);
        @(posedge clk); #1;

        // reset during MAC at k=2 abandons the transaction and clears the stored result
        issue(pack(100, 200, 300, 400), pack(5, 6, 7, 8), 1'b1, w);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("rst_outs", {ra34, ca34, os34, ov34, ra32, ca32, os32, ov32}, 0);
        chk("rst_out_val", longint'(out34) | longint'(out32), 0);
        sb.delete();
        prev34 = 0; prev32 = 0;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_out_after_rst", os34 | os32, 0);
        end
        issue(basic_r, basic_c, 1'b1, w);
        wait_out(lat);
        chk("post_rst_acc", longint'($signed(out34)), 9);
        @(posedge clk); #1;

        // randomized traffic with random output back-pressure
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                r[i*EW +: EW] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
                c[i*EW +: EW] = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            end
            out_o_ack = 1'($urandom_range(0, 1));
            issue(r, c, 1'($urandom_range(0, 1)), w);
            wait_out(lat);
            chk("rand_latency", lat, N + 1);
            if (!out_o_ack) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1 out_o_ack = 1'b1;
            end
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
